// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue bytes in a FIFO,
// a four-state FSM serializes them, and STATUS_ADDR exposes a pollable status word.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] StatusRd,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         bit_idx, bit_n;
  logic [7:0]         sh, sh_n;
  logic               tx_n;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rptr, wptr;
  logic [FCNT_W-1:0]  count;
  logic               overflow;

  logic fifo_empty, fifo_full, baud_done;
  logic pop, push_req, push, ovf_set, ovf_clr;
  logic unused_wdata;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign baud_done  = (cnt == BAUD_LAST);

  // Push/pop contract: a push is accepted when the FIFO has room or the FSM
  // pops on the same edge; a refused push drops the byte and sets overflow.
  assign push_req = MemWrite && (DataAdr == TX_ADDR);
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && !push;
  assign ovf_clr  = MemWrite && (DataAdr == STATUS_ADDR) && WriteData[3];
  assign unused_wdata = ^WriteData[31:8];

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    sh_n    = sh;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = mem[rptr];
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            sh_n  = sh >> 1;
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_n = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = mem[rptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      sh       <= 8'h00;
      tx       <= 1'b1;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      tx      <= tx_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: reads are always gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= WriteData[7:0];
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign StatusRd  = (DataAdr == STATUS_ADDR) ?
                     {16'h0000, 8'(count), 4'h0, overflow, fifo_full, fifo_empty, busy} :
                     32'h0000_0000;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-timer reference model.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 8;
  localparam logic [31:0] TX_A = 32'hFFFF_0000;
  localparam logic [31:0] ST_A = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, StatusRd;
  logic        tx, busy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued bytes, cycles left in the current frame, byte on air.
  logic [7:0] exp_q[$];
  int         m_rem;
  logic [7:0] m_byte;
  logic       m_ovf;

  mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .TX_ADDR(TX_A), .STATUS_ADDR(ST_A)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .StatusRd(StatusRd), .tx(tx), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (m_rem == 0) return 1'b1;
    slot = (10 * C - m_rem) / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot - 1];
  endfunction

  function automatic logic [31:0] exp_status();
    int sz;
    sz = exp_q.size();
    return {16'h0000, 8'(sz), 4'h0, m_ovf, (sz == D), (sz == 0), (m_rem > 0)};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_rem  = 0;
    m_byte = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    int   sz;
    logic pop, push_req, acc;
    sz       = exp_q.size();
    pop      = (sz > 0) && (m_rem <= 1);
    push_req = we && (adr == TX_A);
    acc      = push_req && ((sz < D) || pop);
    if (pop) begin
      m_byte = exp_q.pop_front();
      m_rem  = 10 * C;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (acc) exp_q.push_back(wd[7:0]);
    if (push_req && !acc) m_ovf = 1'b1;
    else if (we && adr == ST_A && wd[3]) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
    #1;
    check("status", StatusRd, (adr == ST_A) ? exp_status() : 32'h0);
    @(posedge clk);
    model_step(we, adr, wd);
    #1;
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, ST_A, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    model_clear();
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic random_phase(input int n, input int pct);
    int r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < pct) begin
        r = $urandom_range(0, 9);
        if (r < 7)       cycle(1'b1, TX_A, $urandom);
        else if (r < 9)  cycle(1'b1, ST_A, $urandom);
        else             cycle(1'b1, 32'h0000_1000 + $urandom_range(0, 255) * 4, $urandom);
      end else begin
        cycle(1'b0, ($urandom_range(0, 1) == 1) ? ST_A : $urandom, $urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
    model_clear();
    do_reset();

    // Idle status, other-address read, unmapped store
    cycle(1'b0, ST_A, 32'h0);
    cycle(1'b0, 32'h0000_1234, 32'h0);
    cycle(1'b1, 32'h0000_0100, 32'h55);
    cycle(1'b0, ST_A, 32'h0);

    // Single byte, then back-to-back pair
    cycle(1'b1, TX_A, 32'h0000_0055);
    idle(45);
    cycle(1'b1, TX_A, 32'hDEAD_BEA3);
    cycle(1'b1, TX_A, 32'h0000_000F);
    idle(85);

    // Overflow: ten stores from idle, ninth lands in the last free slot
    for (int i = 0; i < 10; i++) cycle(1'b1, TX_A, $urandom);
    cycle(1'b0, ST_A, 32'h0);
    cycle(1'b1, ST_A, 32'hFFFF_FFF8);
    cycle(1'b0, ST_A, 32'h0);
    cycle(1'b1, ST_A, 32'h0000_0004);
    idle(9 * 10 * C + 10);

    random_phase(1500, 40);
    random_phase(1500, 3);
    idle(D * 10 * C + 10);

    // Reset during data bit 3 with two bytes queued
    cycle(1'b1, TX_A, 32'h0000_0005);
    cycle(1'b1, TX_A, $urandom);
    cycle(1'b1, TX_A, $urandom);
    for (int i = 0; i < 100; i++) begin
      if (m_rem > 0 && ((10 * C - m_rem) / C) == 4) break;
      cycle(1'b0, ST_A, 32'h0);
    end
    check("reached_bit3", {31'b0, (m_rem > 0 && ((10 * C - m_rem) / C) == 4)}, 32'h1);
    do_reset();
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the processor's data-memory port. It consumes store transactions (MemWrite, DataAdr, WriteData) aimed at two reserved addresses. Bytes are buffered in a small FIFO and serialized on a single 8N1 line. A status word is returned to the processor's load path for polling.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥2.
- FIFO_DEPTH, 8: byte FIFO entries; must be a power of two, ≥2.
- TX_ADDR, 32'hFFFF_0000: store here pushes WriteData[7:0].
- STATUS_ADDR, 32'hFFFF_0004: load here returns status; store here clears flags.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- MemWrite  input  1  processor store strobe, sampled on rising clk.
- DataAdr  input  32  processor byte address.
- WriteData  input  32  processor store data.
- StatusRd  output  32  combinational status word, valid whenever DataAdr==STATUS_ADDR, else 32'h0.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is being shifted out.

## Operation
- Push: MemWrite & DataAdr==TX_ADDR at a rising edge writes WriteData[7:0] into the FIFO. WriteData[31:8] is ignored.
- The push is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and the sticky overflow flag is set.
- Flag clear: MemWrite & DataAdr==STATUS_ADDR & WriteData[3]==1 clears overflow. All other bits of that store are ignored.
- If an overflow set and a clear land on the same edge, the set wins.
- Status word layout:
  - bit0 busy
  - bit1 fifo_empty
  - bit2 fifo_full
  - bit3 overflow
  - bits[7:4] reserved 0
  - bits[15:8] fifo count (zero-extended)
  - bits[31:16] 0
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits and a count register of $clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- TX FSM states:
  - IDLE: tx=1, busy=0. If the FIFO is non-empty, pop the head into shift register sh and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles per bit, then shift sh right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START directly (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame format: LSB first, 8 data bits, no parity, 1 stop bit; 10·CLKS_PER_BIT cycles per frame.
- Baud counter width is $clog2(CLKS_PER_BIT). It resets to 0 on every state entry and on every data-bit boundary.
- tx is driven from a register, with no combinational glitches.

## Timing
- Reset values: tx=1, busy=0, state=IDLE, FIFO empty (count 0, pointers 0), overflow=0, sh=0, counters 0. Resulting StatusRd at STATUS_ADDR is 32'h0000_0002.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronous). The queued bytes and the partial frame are discarded.
- Latency, store to start bit:
  - Store captured at edge N; the FIFO is non-empty after N.
  - The FSM pops at edge N+1; tx falls and busy rises after N+1.
- Start bit: tx=0 for exactly CLKS_PER_BIT cycles.
- busy timing: busy=1 from the pop edge through the last STOP cycle. When the FIFO is empty, it falls on the edge that returns to IDLE.
- Status content: StatusRd reflects the register state before the current edge. A store and a status read in the same cycle do not bypass.
- Full boundary: with count==FIFO_DEPTH, a push without a simultaneous pop sets overflow and leaves the FIFO unchanged.
- Empty boundary: a pop never occurs when count==0.

## Test plan
- Single byte, CLKS_PER_BIT=4: store 32'h0000_0055 to TX_ADDR → tx sequence (4 cycles each) 0,1,0,1,0,1,0,1,0,1; busy high 40 cycles; start bit begins 1 cycle after the store edge.
- Back-to-back, CLKS_PER_BIT=4: store 8'hA3 then 8'h0F on consecutive cycles → two frames with no idle gap (80 consecutive busy cycles); data bits LSB first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Overflow, FIFO_DEPTH=8: while the first frame is in flight, store 10 bytes (9 land in FIFO slots after the initial pop) → status bit2=1, bit3=1, count=8; exactly 9 frames are transmitted in order; the 10th byte is absent.
- Flag clear: after overflow, store 32'h8 to STATUS_ADDR → bit3 reads 0 next cycle. Same-edge overflow and clear → bit3 stays 1.
- Status and idle: after reset, StatusRd with DataAdr=STATUS_ADDR is 32'h0000_0002. With any other DataAdr it is 32'h0. A store to an unmapped address leaves tx=1 and count 0.
- Reset mid-operation: assert reset during DATA bit 3 of a frame with 2 bytes queued → tx=1 and busy=0 immediately; after release, status is 32'h0000_0002 and no further frames are sent.
